// File: rtl/gonso_frame_sequencer.sv
// rtl/gonso_frame_sequencer.sv - raster-order frame sequencer from pixel shader to paced pixel pins
module gonso_frame_sequencer #(
    parameter int X_BITS      = 6,
    parameter int Y_BITS      = 6,
    parameter int COLOR_W     = 8,
    parameter int STROBE_HIGH = 2,
    parameter int STROBE_LOW  = 2
) (
    input  logic               clock,
    input  logic               resetb,
    input  logic               start,
    input  logic               abort,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [X_BITS-1:0]  req_x,
    output logic [Y_BITS-1:0]  req_y,
    input  logic               rsp_valid,
    input  logic [COLOR_W-1:0] rsp_color,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_write,
    output logic               busy,
    output logic               done,
    output logic [15:0]        frame_cnt,
    output logic               rsp_err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(STROBE_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(STROBE_LOW - 1);
    localparam logic [X_BITS-1:0] X_MAX  = '1;
    localparam logic [Y_BITS-1:0] Y_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT_HI,
        S_OUT_LO,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [X_BITS-1:0]    x_q, x_d;
    logic [Y_BITS-1:0]    y_q, y_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COLOR_W-1:0]   pix_color_q, pix_color_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 rsp_err_q, rsp_err_d;

    // State and datapath registers; reset is asynchronous so the pins go quiet immediately.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            pix_color_q <= '0;
            frame_cnt_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            pix_color_q <= pix_color_d;
            frame_cnt_q <= frame_cnt_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and strobe decode; abort overrides everything and silences the outputs that cycle.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        pix_color_d = pix_color_q;
        frame_cnt_d = frame_cnt_q;
        // A response is only expected while waiting; anything else is a protocol error.
        rsp_err_d   = rsp_err_q | (rsp_valid && (state_q != S_WAIT));
        req_valid   = 1'b0;
        pix_write   = 1'b0;
        done        = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_REQ;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                S_REQ: begin
                    req_valid = 1'b1;
                    if (req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        pix_color_d = rsp_color;
                        cnt_d       = '0;
                        state_d     = S_OUT_HI;
                    end
                end
                S_OUT_HI: begin
                    pix_write = 1'b1;
                    if (cnt_q == HI_LAST) begin
                        cnt_d   = '0;
                        state_d = S_OUT_LO;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_OUT_LO: begin
                    if (cnt_q == LO_LAST) begin
                        cnt_d = '0;
                        if ((x_q == X_MAX) && (y_q == Y_MAX)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_REQ;
                            if (x_q == X_MAX) begin
                                x_d = '0;
                                y_d = y_q + 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    done        = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign req_x     = x_q;
    assign req_y     = y_q;
    assign pix_color = pix_color_q;
    assign frame_cnt = frame_cnt_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gonso_frame_sequencer.sv
// tb/tb_gonso_frame_sequencer.sv - self-checking bench for gonso_frame_sequencer
module tb_gonso_frame_sequencer;

    localparam int NPIX = 4096;

    logic        clock;
    logic        resetb;
    logic        start;
    logic        abort;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_x;
    logic [5:0]  req_y;
    logic        rsp_valid;
    logic [7:0]  rsp_color;
    logic [7:0]  pix_color;
    logic        pix_write;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;
    logic        rsp_err;

    gonso_frame_sequencer #(
        .X_BITS(6), .Y_BITS(6), .COLOR_W(8), .STROBE_HIGH(2), .STROBE_LOW(2)
    ) dut (
        .clock(clock), .resetb(resetb), .start(start), .abort(abort),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_color(rsp_color), .pix_color(pix_color),
        .pix_write(pix_write), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .rsp_err(rsp_err)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // model state (owned by the compare process)
    int          k = 0;
    int          pulses = 0;
    logic [15:0] frames_done = 16'd0;
    bit          model_busy = 0;
    bit          prev_pw = 0;
    bit          lo_arm = 0;
    int          hi_len = 0;
    int          lo_len = 0;
    int          hs_cyc[2];
    logic [7:0]  cap[NPIX];

    // owned by main
    bit exp_rsp_err = 0;
    bit stall_en = 0;
    int stray_cnt = 0;
    // owned by stall / shader processes
    bit stalled = 0;
    int stray_done = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Colour the shader returns for raster pixel index i.
    function automatic logic [31:0] colour_of(input int i);
        int j;
        j = (i % NPIX + NPIX) % NPIX;
        return 32'((j % 64) ^ (j / 64));
    endfunction

    // Compare process: checks every cycle against the raster/pacing model.
    always @(negedge clock) begin
        if (!resetb) begin
            chk("rst_req_valid", req_valid, 0);
            chk("rst_pix_write", pix_write, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_rsp_err", rsp_err, 0);
            k = 0; pulses = 0; frames_done = 0; model_busy = 0;
            prev_pw = 0; lo_arm = 0;
        end else begin
            chk("busy", busy, model_busy);
            chk("frame_cnt", frame_cnt, frames_done);
            chk("rsp_err", rsp_err, exp_rsp_err);
            chk("write_and_req", pix_write & req_valid, 0);
            if (abort) begin
                chk("abort_req_valid", req_valid, 0);
                chk("abort_pix_write", pix_write, 0);
                chk("abort_done", done, 0);
                model_busy = 0; prev_pw = 0; lo_arm = 0;
            end else if (!model_busy) begin
                chk("idle_pix_write", pix_write, 0);
                chk("idle_req_valid", req_valid, 0);
                chk("idle_done", done, 0);
                if (start) begin
                    k = 0; pulses = 0; model_busy = 1; prev_pw = 0; lo_arm = 0;
                end
            end else begin
                if (req_valid && req_ready) begin
                    chk("req_x", req_x, k % 64);
                    chk("req_y", req_y, k / 64);
                    if (k < 2) hs_cyc[k] = cyc;
                    k++;
                end
                if (pix_write) begin
                    if (!prev_pw) begin
                        pulses++;
                        hi_len = 1;
                        cap[(k - 1 + NPIX) % NPIX] = pix_color;
                    end else begin
                        hi_len++;
                    end
                    chk("pix_color", pix_color, colour_of(k - 1));
                end else if (prev_pw) begin
                    chk("high_len", hi_len, 2);
                    lo_len = 1;
                    lo_arm = 1;
                end else if (lo_arm) begin
                    if (req_valid || done) begin
                        chk("low_len", lo_len, 2);
                        lo_arm = 0;
                    end else begin
                        lo_len++;
                    end
                end
                prev_pw = pix_write;
                if (done) begin
                    chk("done_pixels_req", k, NPIX);
                    chk("done_pulses", pulses, NPIX);
                    frames_done = frames_done + 16'd1;
                    model_busy = 0;
                end
            end
        end
    end

    // Shader: answers each accepted request one cycle later with x^y; also injects stray responses.
    initial begin
        rsp_valid = 1'b0;
        rsp_color = 8'h00;
        forever begin
            @(negedge clock);
            if (resetb && req_valid && req_ready && !abort) begin
                logic [5:0] hx, hy;
                hx = req_x;
                hy = req_y;
                @(posedge clock); #1;
                rsp_valid = 1'b1;
                rsp_color = {2'b00, hx ^ hy};
                @(posedge clock); #1;
                rsp_valid = 1'b0;
            end else if (stray_cnt != stray_done) begin
                @(posedge clock); #1;
                rsp_valid = 1'b1;
                rsp_color = 8'hA5;
                @(posedge clock); #1;
                rsp_valid = 1'b0;
                stray_done++;
            end
        end
    end

    // Ready driver: stalls the request for pixel (5,0) once for five cycles when enabled.
    initial begin
        req_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (stall_en && !stalled && req_valid && req_x == 6'd5 && req_y == 6'd0) begin
                req_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clock); #1;
                    chk("stall_req_valid", req_valid, 1);
                    chk("stall_req_x", req_x, 5);
                    chk("stall_req_y", req_y, 0);
                end
                req_ready = 1'b1;
                stalled = 1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic start_frame();
        pulse_start();
        chk("first_req_valid", req_valid, 1);
        chk("first_req_x", req_x, 0);
        chk("first_req_y", req_y, 0);
    endtask

    task automatic wait_done(input int budget);
        logic [15:0] f0;
        bit ok;
        f0 = frames_done;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clock);
            if (frames_done != f0) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
        #1;
    endtask

    // Leaves the bench at posedge+#1 with the DUT strobing pixel index >= min_k-1.
    task automatic wait_pix(input int min_k, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clock); #1;
            if (k >= min_k && pix_write) begin
                ok = 1;
                break;
            end
        end
        chk("pix_timeout", ok, 1);
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        #1;
        chk("abort_now_pix_write", pix_write, 0);
        chk("abort_now_req_valid", req_valid, 0);
        chk("abort_now_done", done, 0);
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort_busy_next", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        resetb = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_req_x", req_x, 0);
        chk("reset_req_y", req_y, 0);
        chk("reset_pix_color", pix_color, 0);
        chk("reset_busy", busy, 0);
        resetb = 1'b1;

        // Asynchronous reset in the middle of a frame.
        start_frame();
        wait_pix(4, 300);
        #2;
        resetb = 1'b0;
        #1;
        chk("async_pix_write", pix_write, 0);
        chk("async_busy", busy, 0);
        chk("async_req_x", req_x, 0);
        chk("async_pix_color", pix_color, 0);
        @(posedge clock);
        @(posedge clock); #1;
        resetb = 1'b1;
        @(posedge clock); #1;
        chk("post_reset_busy", busy, 0);

        // Full frame at full rate.
        start_frame();
        wait_done(30000);
        chk("frame1_cnt", frame_cnt, 16'd1);
        chk("frame1_pulses", pulses, 4096);
        chk("pixel_period", hs_cyc[1] - hs_cyc[0], 6);
        chk("cap_5_3", cap[3 * 64 + 5], 8'h06);
        chk("cap_63_0", cap[63], 8'h3F);
        chk("cap_1_1", cap[65], 8'h00);
        chk("cap_62_63", cap[4094], 8'h01);
        chk("idle_after_done", busy, 0);

        // Frame with a stalled request at (5,0) and a start pulse while busy.
        stall_en = 1;
        start_frame();
        wait_pix(300, 3000);
        pulse_start();
        wait_done(30000);
        chk("stall_seen", stalled, 1);
        chk("frame2_cnt", frame_cnt, 16'd2);
        chk("frame2_pulses", pulses, 4096);

        // Abort at pixel 100, then restart from (0,0).
        start_frame();
        wait_pix(101, 2000);
        pulse_abort();
        repeat (20) @(posedge clock);
        #1;
        chk("abort_no_frame", frame_cnt, 16'd2);
        start_frame();
        wait_pix(3, 200);
        pulse_abort();

        // Stray response while idle.
        held = 8'(colour_of(k - 1));
        chk("held_colour", pix_color, held);
        stray_cnt = 1;
        begin
            bit ok;
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(posedge clock); #2;
                if (stray_done == stray_cnt) begin
                    ok = 1;
                    break;
                end
            end
            chk("stray_timeout", ok, 1);
        end
        exp_rsp_err = 1;
        chk("stray_rsp_err", rsp_err, 1);
        chk("stray_pix_write", pix_write, 0);
        chk("stray_pix_color", pix_color, held);
        repeat (5) @(posedge clock);
        #1;
        chk("final_frame_cnt", frame_cnt, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
